// File: rtl/cpu_datapath.sv
// cpu_datapath: register-transfer datapath (PC, MAR, MBR, IR, BR, ACC, MR, DR),
// a 16-bit combinational ALU and a 256-word main memory, sequenced by a
// microprogrammed control unit through the control word C and ALU opcode OP.
module cpu_datapath #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [16:0]       C,
  input  logic [3:0]        OP,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [7:0]        ir,
  output logic              acc_neg,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] mr,
  output logic [DATA_W-1:0] dr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MPY  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;

  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;
  logic [DATA_W-1:0] br;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic              shift_op;
  logic              acc_we;

  // Sequencing bits belong to the control unit and have no effect here.
  logic unused_ctrl;
  assign unused_ctrl = ^C[2:0];

  assign acc_neg = acc[DATA_W-1];
  assign mem_rd  = mem[mar];

  // ALU operand gating: unselected operands read as zero.
  always_comb begin
    alu_a = C[15] ? acc : '0;
    alu_b = C[14] ? br  : '0;
  end

  // Signed full-width product; low half to ACC, high half to MR.
  assign prod = $signed({{DATA_W{alu_a[DATA_W-1]}}, alu_a})
              * $signed({{DATA_W{alu_b[DATA_W-1]}}, alu_b});

  // Signed divide truncating toward zero, with divide-by-zero and overflow pinned.
  always_comb begin
    quo = '1;
    rem = alu_a;
    if (alu_b == '0) begin
      quo = '1;
      rem = alu_a;
    end else if (alu_a == SMIN && alu_b == '1) begin
      quo = SMIN;
      rem = '0;
    end else begin
      quo = DATA_W'($signed(alu_a) / $signed(alu_b));
      rem = DATA_W'($signed(alu_a) % $signed(alu_b));
    end
  end

  // ALU result select.
  always_comb begin
    alu_y = alu_a;
    case (OP)
      OP_PASS: alu_y = alu_a;
      OP_ADD:  alu_y = alu_a + alu_b;
      OP_SUB:  alu_y = alu_a - alu_b;
      OP_MPY:  alu_y = prod[DATA_W-1:0];
      OP_DIV:  alu_y = quo;
      OP_AND:  alu_y = alu_a & alu_b;
      OP_OR:   alu_y = alu_a | alu_b;
      OP_XOR:  alu_y = alu_a ^ alu_b;
      OP_NOT:  alu_y = ~alu_b;
      OP_SHR:  alu_y = {alu_a[DATA_W-1], alu_a[DATA_W-1:1]};
      OP_SHL:  alu_y = {alu_a[DATA_W-2:0], 1'b0};
      default: alu_y = alu_a;
    endcase
  end

  // Shifts are in-place on ACC and commit with C15 alone.
  always_comb begin
    shift_op = (OP == OP_SHR) || (OP == OP_SHL);
    acc_we   = C[16] || (C[15] && shift_op);
  end

  // Register transfers; every source is the pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc  <= '0;
      mar <= '0;
      mbr <= '0;
      ir  <= '0;
      br  <= '0;
      acc <= '0;
      mr  <= '0;
      dr  <= '0;
    end else begin
      if (C[10])      mar <= pc;
      else if (C[5])  mar <= mbr[ADDR_W-1:0];

      if (C[11])      mbr <= acc;
      else if (C[3])  mbr <= mem_rd;

      if (C[13])      pc <= mbr[ADDR_W-1:0];
      else if (C[4])  pc <= pc + ADDR_W'(1);

      if (C[6])       ir <= mbr[DATA_W-1 -: 8];

      if (C[9])       br <= {{(DATA_W-ADDR_W){1'b0}}, mbr[ADDR_W-1:0]};
      else if (C[7])  br <= mbr;

      if (acc_we)     acc <= alu_y;
      else if (C[8])  acc <= '0;

      if (C[16] && OP == OP_MPY) mr <= prod[PROD_W-1:DATA_W];
      if (C[16] && OP == OP_DIV) dr <= rem;
    end
  end

  // Main memory write: preload port has priority over the datapath store.
  always_ff @(posedge clk) begin
    if (ld_en)      mem[ld_addr] <= ld_data;
    else if (C[12]) mem[mar]     <= mbr;
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed testbench for cpu_datapath: microstep sequences with hand-computed results.
module tb_cpu_datapath;

  logic        clk;
  logic        rst;
  logic [16:0] C;
  logic [3:0]  OP;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic [7:0]  ir;
  logic        acc_neg;
  logic [15:0] acc;
  logic [7:0]  pc;
  logic [15:0] mr;
  logic [15:0] dr;

  int tests = 0;
  int fails = 0;

  localparam logic [16:0] C3  = 17'h00008;
  localparam logic [16:0] C4  = 17'h00010;
  localparam logic [16:0] C5  = 17'h00020;
  localparam logic [16:0] C6  = 17'h00040;
  localparam logic [16:0] C7  = 17'h00080;
  localparam logic [16:0] C8  = 17'h00100;
  localparam logic [16:0] C9  = 17'h00200;
  localparam logic [16:0] C10 = 17'h00400;
  localparam logic [16:0] C11 = 17'h00800;
  localparam logic [16:0] C12 = 17'h01000;
  localparam logic [16:0] C13 = 17'h02000;
  localparam logic [16:0] C14 = 17'h04000;
  localparam logic [16:0] C15 = 17'h08000;
  localparam logic [16:0] C16 = 17'h10000;

  cpu_datapath dut (
    .clk     (clk),
    .rst     (rst),
    .C       (C),
    .OP      (OP),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ir      (ir),
    .acc_neg (acc_neg),
    .acc     (acc),
    .pc      (pc),
    .mr      (mr),
    .dr      (dr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One microinstruction: drive at negedge, acts on the posedge, then idle.
  task automatic step(input logic [16:0] c, input logic [3:0] op);
    @(negedge clk);
    C  = c;
    OP = op;
    @(posedge clk);
    #1;
    C  = '0;
    OP = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // MBR <= v through MEM[0]; relies on PC == 0.
  task automatic set_mbr(input logic [15:0] v);
    preload(8'h00, v);
    step(C10, 4'h0);
    step(C3, 4'h0);
  endtask

  task automatic set_br(input logic [15:0] v);
    set_mbr(v);
    step(C7, 4'h0);
  endtask

  // ACC <= 0 + v (also leaves BR = v).
  task automatic set_acc(input logic [15:0] v);
    set_br(v);
    step(C14 | C16, 4'h1);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    tests++;
    if ({ir, acc_neg, acc, pc, mr, dr} !== 57'h0) begin
      fails++;
      $display("FAIL reset_outputs: got ir=%h neg=%b acc=%h pc=%h mr=%h dr=%h want all 0",
               ir, acc_neg, acc, pc, mr, dr);
    end
  endtask

  task automatic test_fetch_load();
    preload(8'h00, 16'h0205);
    preload(8'h05, 16'h1234);
    @(negedge clk);
    rst = 1'b1;
    step(C10, 4'h0);
    step(C3, 4'h0);
    step(C4, 4'h0);
    step(C6, 4'h0);
    tests++;
    if (ir !== 8'h02) begin fails++; $display("FAIL fetch_ir: got %h want %h", ir, 8'h02); end
    tests++;
    if (pc !== 8'h01) begin fails++; $display("FAIL fetch_pc: got %h want %h", pc, 8'h01); end
    step(C5, 4'h0);
    step(C3, 4'h0);
    step(C7 | C8, 4'h0);
    step(C14 | C15, 4'h6);
    tests++;
    if (acc !== 16'h0000) begin fails++; $display("FAIL load_no_c16: got %h want %h", acc, 16'h0000); end
    step(C14 | C15 | C16, 4'h6);
    tests++;
    if (acc !== 16'h1234) begin fails++; $display("FAIL load_acc: got %h want %h", acc, 16'h1234); end
  endtask

  task automatic test_add_sub();
    do_reset();
    set_acc(16'h7FFF);
    set_br(16'h0001);
    step(C14 | C15 | C16, 4'h1);
    tests++;
    if (acc !== 16'h8000 || acc_neg !== 1'b1) begin
      fails++; $display("FAIL add_ovf: got acc=%h neg=%b want 8000 1", acc, acc_neg);
    end
    step(C14 | C15 | C16, 4'h2);
    tests++;
    if (acc !== 16'h7FFF || acc_neg !== 1'b0) begin
      fails++; $display("FAIL sub: got acc=%h neg=%b want 7fff 0", acc, acc_neg);
    end
  endtask

  task automatic test_mpy_div();
    do_reset();
    set_acc(16'hFFFE);
    set_br(16'h0003);
    step(C14 | C15 | C16, 4'h3);
    tests++;
    if (acc !== 16'hFFFA || mr !== 16'hFFFF) begin
      fails++; $display("FAIL mpy: got acc=%h mr=%h want fffa ffff", acc, mr);
    end
    set_acc(16'hFFF9);
    set_br(16'h0002);
    step(C14 | C15 | C16, 4'h4);
    tests++;
    if (acc !== 16'hFFFD || dr !== 16'hFFFF) begin
      fails++; $display("FAIL div_neg: got acc=%h dr=%h want fffd ffff", acc, dr);
    end
    tests++;
    if (mr !== 16'hFFFF) begin fails++; $display("FAIL mr_hold_on_div: got %h want %h", mr, 16'hFFFF); end
    set_acc(16'h0005);
    set_br(16'h0000);
    step(C14 | C15 | C16, 4'h4);
    tests++;
    if (acc !== 16'hFFFF || dr !== 16'h0005) begin
      fails++; $display("FAIL div_zero: got acc=%h dr=%h want ffff 0005", acc, dr);
    end
    set_acc(16'h8000);
    set_br(16'hFFFF);
    step(C14 | C15 | C16, 4'h4);
    tests++;
    if (acc !== 16'h8000 || dr !== 16'h0000) begin
      fails++; $display("FAIL div_ovf: got acc=%h dr=%h want 8000 0000", acc, dr);
    end
  endtask

  task automatic test_logic_shift();
    do_reset();
    set_acc(16'h8001);
    step(C15, 4'h9);
    tests++;
    if (acc !== 16'hC000) begin fails++; $display("FAIL shr: got %h want %h", acc, 16'hC000); end
    step(C15, 4'hA);
    tests++;
    if (acc !== 16'h8000) begin fails++; $display("FAIL shl: got %h want %h", acc, 16'h8000); end
    set_br(16'h00FF);
    step(C14 | C16, 4'h8);
    tests++;
    if (acc !== 16'hFF00) begin fails++; $display("FAIL not: got %h want %h", acc, 16'hFF00); end
    set_acc(16'hF0F0);
    set_br(16'h0FF0);
    step(C14 | C15 | C16, 4'h7);
    tests++;
    if (acc !== 16'hFF00) begin fails++; $display("FAIL xor: got %h want %h", acc, 16'hFF00); end
  endtask

  task automatic test_priority();
    do_reset();
    set_acc(16'h1111);
    set_br(16'h0005);
    step(C8 | C14 | C16, 4'h1);
    tests++;
    if (acc !== 16'h0005) begin fails++; $display("FAIL c16_over_c8: got %h want %h", acc, 16'h0005); end
    set_mbr(16'hABCD);
    step(C7 | C9, 4'h0);
    step(C14 | C16, 4'h1);
    tests++;
    if (acc !== 16'h00CD) begin fails++; $display("FAIL c9_over_c7: got %h want %h", acc, 16'h00CD); end
  endtask

  task automatic test_store();
    do_reset();
    set_acc(16'hABCD);
    set_mbr(16'h0010);
    step(C5, 4'h0);
    step(C11, 4'h0);
    step(C12, 4'h0);
    step(C3, 4'h0);
    step(C7, 4'h0);
    step(C14 | C16, 4'h1);
    tests++;
    if (acc !== 16'hABCD) begin fails++; $display("FAIL store_mem16: got %h want %h", acc, 16'hABCD); end
    @(negedge clk);
    C = C12; ld_en = 1'b1; ld_addr = 8'h10; ld_data = 16'h0001;
    @(posedge clk);
    #1;
    C = '0; ld_en = 1'b0;
    step(C3, 4'h0);
    step(C7, 4'h0);
    step(C14 | C16, 4'h1);
    tests++;
    if (acc !== 16'h0001) begin fails++; $display("FAIL ld_over_c12: got %h want %h", acc, 16'h0001); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_acc(16'hFFFE);
    set_br(16'h0003);
    step(C14 | C15 | C16, 4'h3);
    set_mbr(16'h5A10);
    step(C6, 4'h0);
    step(C4, 4'h0);
    step(C7, 4'h0);
    tests++;
    if (ir !== 8'h5A || pc !== 8'h01 || mr !== 16'hFFFF) begin
      fails++; $display("FAIL pre_reset_state: got ir=%h pc=%h mr=%h want 5a 01 ffff", ir, pc, mr);
    end
    @(negedge clk);
    C = C14 | C16; OP = 4'h1;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({ir, acc_neg, acc, pc, mr, dr} !== 57'h0) begin
      fails++;
      $display("FAIL async_reset: got ir=%h neg=%b acc=%h pc=%h mr=%h dr=%h want all 0",
               ir, acc_neg, acc, pc, mr, dr);
    end
    @(posedge clk);
    #1;
    tests++;
    if (acc !== 16'h0000) begin fails++; $display("FAIL reset_hold: got %h want %h", acc, 16'h0000); end
    @(negedge clk);
    C = '0; OP = '0;
    rst = 1'b1;
    set_mbr(16'h0010);
    step(C5, 4'h0);
    step(C3, 4'h0);
    step(C7, 4'h0);
    step(C14 | C16, 4'h1);
    tests++;
    if (acc !== 16'h0001) begin fails++; $display("FAIL mem_retained: got %h want %h", acc, 16'h0001); end
    set_mbr(16'h00FF);
    step(C4 | C13, 4'h0);
    tests++;
    if (pc !== 8'hFF) begin fails++; $display("FAIL c13_over_c4: got %h want %h", pc, 8'hFF); end
    step(C4, 4'h0);
    tests++;
    if (pc !== 8'h00) begin fails++; $display("FAIL pc_wrap: got %h want %h", pc, 8'h00); end
  endtask

  initial begin
    rst = 1'b0;
    C = '0;
    OP = '0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    test_reset();
    test_fetch_load();
    test_add_sub();
    test_mpy_div();
    test_logic_shift();
    test_priority();
    test_store();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
